// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FUNCT3 width codes,
// FSM state encoding and the store legality check.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Stores only know b/h/w; unsigned widths and reserved codes are faults.
    function automatic logic store_fault(input logic [2:0] funct3, input logic [1:0] byte_off);
        logic fault;
        case (funct3)
            F3_B:    fault = 1'b0;
            F3_H:    fault = byte_off[0];
            F3_W:    fault = (byte_off != 2'b00);
            default: fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage load/store bus. Handshake: READ or WRITE is sampled only while
// the responder is idle; BUSY stalls the pipeline and the first BUSY=0 cycle
// after an accepted request is the one in which READ_DATA/ERROR are valid.
interface dmem_responder_if;
    logic        READ;
    logic        WRITE;
    logic [31:0] ADDRESS;
    logic [31:0] WRITE_DATA;
    logic [2:0]  FUNCT3;
    logic [31:0] READ_DATA;
    logic        BUSY;
    logic        ERROR;

    modport master (
        output READ, WRITE, ADDRESS, WRITE_DATA, FUNCT3,
        input  READ_DATA, BUSY, ERROR
    );

    modport slave (
        input  READ, WRITE, ADDRESS, WRITE_DATA, FUNCT3,
        output READ_DATA, BUSY, ERROR
    );
endinterface

// File: rtl/dmem_load_align.sv
// Load lane selection and sign/zero extension; flags misaligned or
// illegal width codes and forces a zero result in that case.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] result,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (byte_off)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = byte_off[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        result     = '0;
        misaligned = 1'b0;
        case (funct3)
            F3_B:  result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU: result = {24'd0, byte_sel};
            F3_H: begin
                if (byte_off[0]) misaligned = 1'b1;
                else             result = {{16{half_sel[15]}}, half_sel};
            end
            F3_HU: begin
                if (byte_off[0]) misaligned = 1'b1;
                else             result = {16'd0, half_sel};
            end
            F3_W: begin
                if (byte_off != 2'b00) misaligned = 1'b1;
                else                   result = word;
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data memory behind the MEM stage: latches a request, stalls for
// LATENCY access cycles, then commits the store or returns the aligned load.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    dmem_responder_if.slave   bus,
    output state_t            state_dbg
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    state_t                  state;
    logic [3:0]              cnt;
    logic                    req_rd;
    logic                    req_wr;
    logic [ADDR_WIDTH+1:0]   req_addr;
    logic [31:0]             req_wdata;
    logic [2:0]              req_f3;
    logic [31:0]             read_data_q;
    logic                    error_q;

    logic [31:0]             mem [0:DEPTH-1];

    logic                    req;
    logic                    access_fire;
    logic                    fault;
    logic                    mem_we;
    logic [31:0]             word;
    logic [31:0]             load_result;
    logic                    load_fault;
    logic [3:0]              be;
    logic [31:0]             wdata_rep;
    logic                    unused_addr_hi;

    assign req            = bus.READ | bus.WRITE;
    assign unused_addr_hi = ^bus.ADDRESS[31:ADDR_WIDTH+2];

    // BUSY is raised in the accepting IDLE cycle so the pipeline stalls at once.
    assign bus.BUSY      = (state == ACCESS) || ((state == IDLE) && req && !RESET);
    assign bus.READ_DATA = read_data_q;
    assign bus.ERROR     = error_q;
    assign state_dbg     = state;

    assign word = mem[req_addr[ADDR_WIDTH+1:2]];

    dmem_load_align u_load_align (
        .word       (word),
        .byte_off   (req_addr[1:0]),
        .funct3     (req_f3),
        .result     (load_result),
        .misaligned (load_fault)
    );

    // READ and WRITE together is a store that is always rejected.
    assign fault       = req_wr ? (req_rd || store_fault(req_f3, req_addr[1:0])) : load_fault;
    assign access_fire = (state == ACCESS) && (cnt == 4'd0);
    assign mem_we      = access_fire && req_wr && !fault;

    always_comb begin
        be        = 4'b0000;
        wdata_rep = req_wdata;
        case (req_f3)
            F3_B: begin
                be[req_addr[1:0]] = 1'b1;
                wdata_rep         = {4{req_wdata[7:0]}};
            end
            F3_H: begin
                be        = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[req_addr[ADDR_WIDTH+1:2]][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            req_rd      <= 1'b0;
            req_wr      <= 1'b0;
            req_addr    <= '0;
            req_wdata   <= '0;
            req_f3      <= '0;
            read_data_q <= '0;
            error_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    error_q <= 1'b0;
                    if (req) begin
                        req_rd    <= bus.READ;
                        req_wr    <= bus.WRITE;
                        req_addr  <= bus.ADDRESS[ADDR_WIDTH+1:0];
                        req_wdata <= bus.WRITE_DATA;
                        req_f3    <= bus.FUNCT3;
                        cnt       <= 4'(LATENCY - 1);
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        error_q <= fault;
                        if (!req_wr) read_data_q <= load_result;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    error_q <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    error_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed checks of dmem_responder against a byte-level
// reference memory model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int LAT = 4;
    localparam int AW  = 10;

    logic   CLK;
    logic   RESET;
    state_t dut_state;

    dmem_responder_if bus ();

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .bus       (bus),
        .state_dbg (dut_state)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] model_mem [0:(2**AW)-1];
    logic [31:0] model_rd;
    logic        model_err;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Byte-addressed view of the memory: width from FUNCT3, alignment by modulo.
    function automatic void model_access(input bit rd, input bit wr, input logic [31:0] addr,
                                         input logic [31:0] wd, input logic [2:0] f3);
        int size;
        int off;
        int idx;
        bit illegal;
        bit mis;
        logic [31:0] w;
        logic [31:0] mask;
        logic [31:0] v;
        off = int'(addr & 32'd3);
        idx = int'((addr >> 2) & ((1 << AW) - 1));
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        illegal = (size == 0) || (wr && f3[2]);
        mis = !illegal && ((off % size) != 0);
        model_err = illegal || mis || (rd && wr);
        if (wr) begin
            if (!model_err) begin
                w = model_mem[idx];
                for (int i = 0; i < size; i++) begin
                    w = w & ~(32'hFF << (8 * (off + i)));
                    w = w | (((wd >> (8 * i)) & 32'hFF) << (8 * (off + i)));
                end
                model_mem[idx] = w;
            end
        end else if (model_err) begin
            model_rd = 32'd0;
        end else begin
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
            v = (model_mem[idx] >> (8 * off)) & mask;
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
            model_rd = v;
        end
    endfunction

    task automatic set_idle();
        bus.READ       = 1'b0;
        bus.WRITE      = 1'b0;
        bus.ADDRESS    = 32'd0;
        bus.WRITE_DATA = 32'd0;
        bus.FUNCT3     = 3'd0;
    endtask

    // One request through the bus; keep=1 leaves the request driven after DONE
    // so the caller can issue the next one with no idle gap.
    task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [2:0] f3,
                          input bit keep, input bit flush, input string name);
        int  n;
        bit  done;
        bit  err_seen;
        model_access(rd, wr, addr, wd, f3);
        @(negedge CLK);
        bus.READ = rd; bus.WRITE = wr; bus.ADDRESS = addr;
        bus.WRITE_DATA = wd; bus.FUNCT3 = f3;
        #1;
        checks++;
        if (bus.BUSY !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_start got %b want 1", name, bus.BUSY);
        end
        n = 1; done = 0; err_seen = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge CLK);
            if (flush) begin
                bus.READ = 1'b0; bus.WRITE = 1'b0;
                bus.ADDRESS = $urandom; bus.WRITE_DATA = $urandom;
                bus.FUNCT3 = 3'($urandom_range(0, 7));
            end
            #1;
            if (bus.BUSY === 1'b1) begin
                n++;
                if (bus.ERROR !== 1'b0) err_seen = 1;
            end else begin
                done = 1;
            end
        end
        checks++;
        if (!done || n != LAT + 1) begin
            errors++;
            $display("FAIL %s busy_len got %0d (done=%0d) want %0d", name, n, done, LAT + 1);
        end
        checks++;
        if (bus.READ_DATA !== model_rd) begin
            errors++;
            $display("FAIL %s read_data got %h want %h", name, bus.READ_DATA, model_rd);
        end
        checks++;
        if (bus.ERROR !== model_err) begin
            errors++;
            $display("FAIL %s error_done got %b want %b", name, bus.ERROR, model_err);
        end
        checks++;
        if (err_seen) begin
            errors++;
            $display("FAIL %s error_while_busy got 1 want 0", name);
        end
        if (!keep) begin
            @(negedge CLK);
            set_idle();
            #1;
            checks++;
            if (bus.BUSY !== 1'b0 || bus.ERROR !== 1'b0) begin
                errors++;
                $display("FAIL %s idle_after got busy=%b err=%b want 0 0", name, bus.BUSY, bus.ERROR);
            end
            checks++;
            if (bus.READ_DATA !== model_rd) begin
                errors++;
                $display("FAIL %s read_data_hold got %h want %h", name, bus.READ_DATA, model_rd);
            end
        end
    endtask

    task automatic expect_rd(input logic [31:0] want, input string name);
        checks++;
        if (bus.READ_DATA !== want) begin
            errors++;
            $display("FAIL %s const got %h want %h", name, bus.READ_DATA, want);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        set_idle();
        model_rd = 32'd0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        #1;
        checks++;
        if (bus.READ_DATA !== 32'd0 || bus.ERROR !== 1'b0 || bus.BUSY !== 1'b0 || dut_state !== IDLE) begin
            errors++;
            $display("FAIL reset got rd=%h err=%b busy=%b st=%0d want 0 0 0 0",
                     bus.READ_DATA, bus.ERROR, bus.BUSY, dut_state);
        end
    endtask

    task automatic test_word();
        for (int i = 0; i < 16; i++)
            do_req(0, 1, 32'(i * 4), $urandom, F3_W, 0, 0, "init_fill");
        do_req(0, 1, 32'h200, 32'h1357_9BDF, F3_W, 0, 0, "init_200");
        do_req(0, 1, 32'h100, 32'hDEAD_BEEF, F3_W, 0, 0, "sw_100");
        do_req(1, 0, 32'h100, 32'd0, F3_W, 0, 0, "lw_100");
        expect_rd(32'hDEAD_BEEF, "lw_100");
    endtask

    task automatic test_subword();
        do_req(1, 0, 32'h103, 32'd0, F3_B, 0, 0, "lb_103");
        expect_rd(32'hFFFF_FFDE, "lb_103");
        do_req(1, 0, 32'h103, 32'd0, F3_BU, 0, 0, "lbu_103");
        expect_rd(32'h0000_00DE, "lbu_103");
        do_req(1, 0, 32'h102, 32'd0, F3_H, 0, 0, "lh_102");
        expect_rd(32'hFFFF_DEAD, "lh_102");
        do_req(1, 0, 32'h100, 32'd0, F3_HU, 0, 0, "lhu_100");
        expect_rd(32'h0000_BEEF, "lhu_100");
    endtask

    task automatic test_store_lanes();
        do_req(0, 1, 32'h101, 32'hFFFF_FF55, F3_B, 0, 0, "sb_101");
        do_req(1, 0, 32'h100, 32'd0, F3_W, 0, 0, "lw_after_sb");
        expect_rd(32'hDEAD_55EF, "lw_after_sb");
        do_req(0, 1, 32'h102, 32'hABCD_1234, F3_H, 0, 0, "sh_102");
        do_req(1, 0, 32'h100, 32'd0, F3_W, 0, 0, "lw_after_sh");
        expect_rd(32'h1234_55EF, "lw_after_sh");
    endtask

    task automatic test_errors();
        do_req(1, 0, 32'h102, 32'd0, F3_W, 0, 0, "lw_mis");
        expect_rd(32'd0, "lw_mis");
        do_req(0, 1, 32'h101, 32'h0000_9999, F3_H, 0, 0, "sh_mis");
        do_req(1, 0, 32'h100, 32'd0, F3_W, 0, 0, "lw_after_sh_mis");
        expect_rd(32'h1234_55EF, "lw_after_sh_mis");
        do_req(1, 0, 32'h100, 32'd0, 3'b011, 0, 0, "load_f3_011");
        do_req(0, 1, 32'h100, 32'h0000_0077, F3_BU, 0, 0, "store_f3_bu");
        do_req(1, 1, 32'h100, 32'h0000_0000, F3_W, 0, 0, "read_and_write");
        do_req(1, 0, 32'h100, 32'd0, F3_W, 0, 0, "lw_after_faults");
        expect_rd(32'h1234_55EF, "lw_after_faults");
    endtask

    task automatic test_hold_back_to_back();
        do_req(1, 0, 32'h100, 32'd0, F3_W, 1, 0, "held_first");
        do_req(1, 0, 32'h100, 32'd0, F3_W, 0, 0, "held_second");
        do_req(0, 1, 32'h004, 32'h0BAD_F00D, F3_W, 1, 0, "b2b_sw");
        do_req(1, 0, 32'h004, 32'd0, F3_H, 1, 0, "b2b_lh");
        do_req(1, 0, 32'h006, 32'd0, F3_BU, 0, 0, "b2b_lbu");
        do_req(1, 0, 32'h008, 32'd0, F3_W, 0, 1, "flush_lw");
        do_req(0, 1, 32'h00C, 32'h8765_4321, F3_W, 0, 1, "flush_sw");
        do_req(1, 0, 32'h00C, 32'd0, F3_W, 0, 0, "lw_after_flush_sw");
    endtask

    task automatic test_reset_mid_access();
        do_req(1, 0, 32'h100, 32'd0, F3_W, 0, 0, "pre_reset_lw");
        @(negedge CLK);
        bus.WRITE = 1'b1; bus.ADDRESS = 32'h200;
        bus.WRITE_DATA = 32'hAAAA_AAAA; bus.FUNCT3 = F3_W;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        set_idle();
        #1;
        checks++;
        if (bus.BUSY !== 1'b0 || bus.READ_DATA !== 32'd0 || bus.ERROR !== 1'b0 || dut_state !== IDLE) begin
            errors++;
            $display("FAIL reset_mid_access got busy=%b rd=%h err=%b st=%0d want 0 0 0 0",
                     bus.BUSY, bus.READ_DATA, bus.ERROR, dut_state);
        end
        model_rd = 32'd0;
        @(negedge CLK);
        RESET = 1'b0;
        do_req(1, 0, 32'h200, 32'd0, F3_W, 0, 0, "lw_200_after_abort");
        expect_rd(32'h1357_9BDF, "lw_200_after_abort");
    endtask

    task automatic test_random();
        bit rd;
        bit wr;
        int sel;
        logic [31:0] addr;
        logic [2:0]  f3;
        for (int k = 0; k < 80; k++) begin
            sel = $urandom_range(0, 9);
            rd = (sel <= 3) || (sel >= 8);
            wr = (sel >= 4) && (sel <= 8);
            addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3))
                   | (32'($urandom_range(0, 3)) << 12);
            if ($urandom_range(0, 9) < 7) begin
                case ($urandom_range(0, 4))
                    0: f3 = F3_B;
                    1: f3 = F3_H;
                    2: f3 = F3_W;
                    3: f3 = F3_BU;
                    default: f3 = F3_HU;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            do_req(rd, wr, addr, $urandom, f3,
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), "random");
        end
        @(negedge CLK);
        set_idle();
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_store_lanes();
        test_errors();
        test_hold_back_to_back();
        test_reset_mid_access();
        test_random();
        repeat (2) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
